// File: rtl/toggle_period_meter_if.sv
// Signal bundle for toggle_period_meter: toggling input plus tick/measurement outputs.
// slave = meter side (sig_in in, results out); master = source/monitor side.
interface toggle_period_meter_if #(
  parameter int WIDTH = 32
);
  logic             sig_in;
  logic             rise_tick;
  logic             fall_tick;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic [WIDTH-1:0] high_cycles;
  logic             stalled;

  modport slave (
    input  sig_in,
    output rise_tick,
    output fall_tick,
    output period,
    output period_valid,
    output high_cycles,
    output stalled
  );

  modport master (
    output sig_in,
    input  rise_tick,
    input  fall_tick,
    input  period,
    input  period_valid,
    input  high_cycles,
    input  stalled
  );
endinterface

// File: rtl/toggle_period_meter.sv
// Edge ticks, period/high-time measurement and stall flag for a slow toggling input.
// Ports: clk, nRst (async low), bus (slave): sig_in -> rise/fall_tick, period(_valid), high_cycles, stalled.
// Build option: TOGGLE_METER_SYNC_EN adds a 2-flop synchronizer in front of the edge detector.
module toggle_period_meter #(
  parameter int          WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic                  clk,
  input  logic                  nRst,
  toggle_period_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] TMO    = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] TMO_M1 = WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic             s_q;
  logic             d_q;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] cnt_q;
  logic             armed_q;
  logic             rise_q;
  logic             fall_q;
  logic [WIDTH-1:0] period_q;
  logic             pv_q;
  logic [WIDTH-1:0] high_q;
  logic             stall_q;

`ifdef TOGGLE_METER_SYNC_EN
  logic meta_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      meta_q <= bus.sig_in;
      s_q    <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) s_q <= 1'b0;
    else       s_q <= bus.sig_in;
  end
`endif

  assign rise = s_q & ~d_q;
  assign fall = ~s_q & d_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      d_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
      high_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      d_q    <= s_q;
      rise_q <= rise;
      fall_q <= fall;

      // saturate at the timeout so a dead source never wraps
      if (rise)              cnt_q <= ONE;
      else if (cnt_q != TMO) cnt_q <= cnt_q + ONE;

      if (rise) begin
        // interval ending a stall is untrusted: re-arm only
        if (armed_q && !stall_q) begin
          period_q <= cnt_q;
          pv_q     <= 1'b1;
        end
        armed_q <= 1'b1;
        stall_q <= 1'b0;
      end else begin
        if (cnt_q == TMO_M1) begin
          stall_q <= 1'b1;
          pv_q    <= 1'b0;
        end
        if (fall && armed_q) high_q <= cnt_q;
      end
    end
  end

  assign bus.rise_tick    = rise_q;
  assign bus.fall_tick    = fall_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.high_cycles  = high_q;
  assign bus.stalled      = stall_q;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Randomized/directed bench for toggle_period_meter, WIDTH=16, TIMEOUT_CYCLES=100.
// Reference model works on input sample timestamps, delayed by the build's tick latency.
module tb_toggle_period_meter;

  localparam int W = 16;
  localparam int T = 100;
`ifdef TOGGLE_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic         rt;
    logic         ft;
    logic [W-1:0] per;
    logic         pv;
    logic [W-1:0] hi;
    logic         st;
  } exp_t;

  logic clk = 1'b0;
  logic nRst = 1'b0;

  toggle_period_meter_if #(.WIDTH(W)) bus ();

  toggle_period_meter #(
    .WIDTH(W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;
  int e     = 0;

  // model state, in input-sample time
  int   m_ref;
  bit   m_prev;
  bit   m_armed;
  bit   m_st;
  int   m_per;
  bit   m_pv;
  int   m_hi;
  exp_t pipe[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z = '0;
    m_prev  = 1'b0;
    m_armed = 1'b0;
    m_st    = 1'b0;
    m_per   = 0;
    m_pv    = 1'b0;
    m_hi    = 0;
    // cycles seen by the counter before the first sample reaches it
    m_ref   = (e + 1) - LAT;
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back(z);
  endtask

  function automatic exp_t model_edge(input bit v);
    exp_t x;
    int   age;
    bit   r;
    bit   f;
    r   = v & ~m_prev;
    f   = ~v & m_prev;
    age = e - m_ref;
    if (age > T) age = T;
    if (r) begin
      if (m_armed && !m_st) begin
        m_per = age;
        m_pv  = 1'b1;
      end
      m_armed = 1'b1;
      m_st    = 1'b0;
      m_ref   = e;
    end else begin
      if (age == T - 1) begin
        m_st = 1'b1;
        m_pv = 1'b0;
      end
      if (f && m_armed) m_hi = age;
    end
    m_prev = v;
    x.rt  = r;
    x.ft  = f;
    x.per = W'(m_per);
    x.pv  = m_pv;
    x.hi  = W'(m_hi);
    x.st  = m_st;
    return x;
  endfunction

  // called at a negedge; returns at the following negedge
  task automatic step(input bit v);
    exp_t x;
    bus.sig_in = v;
    @(posedge clk);
    e++;
    pipe.push_back(model_edge(v));
    x = pipe.pop_front();
    #1;
    chk("rise_tick",    32'(bus.rise_tick),    32'(x.rt));
    chk("fall_tick",    32'(bus.fall_tick),    32'(x.ft));
    chk("period",       32'(bus.period),       32'(x.per));
    chk("period_valid", 32'(bus.period_valid), 32'(x.pv));
    chk("high_cycles",  32'(bus.high_cycles),  32'(x.hi));
    chk("stalled",      32'(bus.stalled),      32'(x.st));
    @(negedge clk);
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
    end
  endtask

  task automatic do_reset(input bit rel_v);
    nRst = 1'b0;
    #1;
    chk("rst_rise_tick", 32'(bus.rise_tick),    0);
    chk("rst_fall_tick", 32'(bus.fall_tick),    0);
    chk("rst_period",    32'(bus.period),       0);
    chk("rst_pv",        32'(bus.period_valid), 0);
    chk("rst_high",      32'(bus.high_cycles),  0);
    chk("rst_stalled",   32'(bus.stalled),      0);
    repeat (3) @(negedge clk);
    bus.sig_in = rel_v;
    nRst = 1'b1;
    model_reset();
  endtask

  int k;
  int found;

  initial begin
    bus.sig_in = 1'b0;
    @(negedge clk);

    // 1: quiet after reset
    do_reset(1'b0);
    repeat (20) step(1'b0);
    chk("idle_pv", 32'(bus.period_valid), 0);

    // 2: 5/5 square wave
    wave(5, 5, 3);
    chk("sq_period", 32'(bus.period), 10);
    chk("sq_high",   32'(bus.high_cycles), 5);
    chk("sq_pv",     32'(bus.period_valid), 1);

    // 3: edge latency, then hold high into a stall
    k = e + 1;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      if (found == 0 && bus.rise_tick === 1'b1) found = e;
    end
    chk("rise_latency", 32'(found - k), LAT);

    // 4: stall and recovery
    repeat (100) step(1'b1);
    chk("stall_st",  32'(bus.stalled), 1);
    chk("stall_pv",  32'(bus.period_valid), 0);
    chk("stall_per", 32'(bus.period), 10);
    repeat (5) step(1'b0);
    wave(5, 5, 1);
    chk("resume1_st", 32'(bus.stalled), 0);
    chk("resume1_pv", 32'(bus.period_valid), 0);
    wave(5, 5, 1);
    chk("resume2_per", 32'(bus.period), 10);
    chk("resume2_pv",  32'(bus.period_valid), 1);

    // 5: 3 high / 4 low
    wave(3, 4, 3);
    chk("w34_period", 32'(bus.period), 7);
    chk("w34_high",   32'(bus.high_cycles), 3);

    // randomized waves, occasionally long enough to stall
    for (int p = 0; p < 30; p++) begin
      int h;
      int l;
      h = $urandom_range(1, 12);
      l = ($urandom_range(0, 5) == 0) ? $urandom_range(90, 120)
                                     : $urandom_range(1, 12);
      wave(h, l, 1);
    end

    // 6: reset mid-high, release with input high
    repeat (3) step(1'b1);
    do_reset(1'b1);
    wave(4, 3, 1);
    chk("rst_rise1_pv", 32'(bus.period_valid), 0);
    wave(4, 3, 1);
    chk("rst_rise2_pv",  32'(bus.period_valid), 1);
    chk("rst_rise2_per", 32'(bus.period), 7);

    for (int p = 0; p < 20; p++)
      wave($urandom_range(1, 9), $urandom_range(1, 9), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
